fetch_unit: RTL and testbench

- Instruction-fetch front end of the MIPS core: the consumer of the branch decision PCSrc.
- Owns the PC register and issues word fetches to instruction memory over a req/ack handshake.
- Presents each fetched instruction to decode through a one-entry output register.
- Applies branch and jump redirects, including squashing fetches already in flight.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_unit_pc_next_sel.sv | 30 +++
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Sequential fetch stride in bytes.
    localparam int unsigned PC_INC = 4;

    // Default PC loaded on reset.
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // Word alignment: the low ALIGN_LSBS bits of a redirect target are forced to zero.
    localparam int unsigned ALIGN_LSBS = 2;

endpackage

// File: rtl/fetch_unit_pc_next_sel.sv
// Next-PC selection: sequential increment plus redirect target (jump beats branch), word-aligned.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the selected value is loaded.
// Ports: pc (current fetch PC), pcsrc/branch_target, jump/jump_target in;
//        pc_inc (pc + 4, wrapping), redirect (any redirect this cycle), target (aligned) out.
module pc_next_sel
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              pcsrc,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] pc_inc,
    output logic              redirect,
    output logic [ADDR_W-1:0] target
);

    logic [ADDR_W-1:0] raw_target;

    always_comb begin
        pc_inc     = pc + ADDR_W'(PC_INC);
        redirect   = jump | pcsrc;
        raw_target = jump ? jump_target : branch_target;
        target     = {raw_target[ADDR_W-1:ALIGN_LSBS], {ALIGN_LSBS{1'b0}}};
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, fetches words over req/ack, holds one instruction for decode.
// Latency: ack edge to InstrValid is 1 cycle; redirect to target request is 1 cycle (or after outstanding ack).
// Backpressure: Stall holds the output register and blocks the next fetch; redirects override Stall.
// Ports: clk/rst_n; PCSrc/BranchTarget, Jump/JumpTarget redirects; Stall from decode;
//        imem_req/imem_addr/imem_ack/imem_rdata memory handshake; Instr/InstrPC/InstrValid to decode; PC.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PCSrc,
    input  logic [ADDR_W-1:0] BranchTarget,
    input  logic              Jump,
    input  logic [ADDR_W-1:0] JumpTarget,
    input  logic              Stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       Instr,
    output logic [ADDR_W-1:0] InstrPC,
    output logic              InstrValid,
    output logic [ADDR_W-1:0] PC
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              valid_q, valid_d;
    // squash_q marks the outstanding request as stale; redir_pc_q is where to go once it returns.
    logic              squash_q, squash_d;
    logic [ADDR_W-1:0] redir_pc_q, redir_pc_d;

    logic [ADDR_W-1:0] pc_inc;
    logic              redirect;
    logic [ADDR_W-1:0] target;

    pc_next_sel #(.ADDR_W(ADDR_W)) u_pc_next_sel (
        .pc            (pc_q),
        .pcsrc         (PCSrc),
        .branch_target (BranchTarget),
        .jump          (Jump),
        .jump_target   (JumpTarget),
        .pc_inc        (pc_inc),
        .redirect      (redirect),
        .target        (target)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        squash_d   = squash_q;
        redir_pc_d = redir_pc_q;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    if (redirect) begin
                        // Returning word belongs to the old path; restart at the new target.
                        pc_d     = target;
                        squash_d = 1'b0;
                    end else if (squash_q) begin
                        pc_d     = redir_pc_q;
                        squash_d = 1'b0;
                    end else begin
                        instr_d    = imem_rdata;
                        instr_pc_d = pc_q;
                        valid_d    = 1'b1;
                        pc_d       = pc_inc;
                        state_d    = HOLD;
                    end
                end else if (redirect) begin
                    // Address must stay stable until the ack, so park the target (latest wins).
                    redir_pc_d = target;
                    squash_d   = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    pc_d    = target;
                    state_d = FETCH;
                end else if (!Stall) begin
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            squash_q   <= 1'b0;
            redir_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            squash_q   <= squash_d;
            redir_pc_q <= redir_pc_d;
        end
    end

    assign imem_req   = (state_q == FETCH);
    assign imem_addr  = pc_q;
    assign PC         = pc_q;
    assign Instr      = instr_q;
    assign InstrPC    = instr_pc_q;
    assign InstrValid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: per-cycle vector table plus reset corner sequence.
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        PCSrc;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        Stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic        InstrValid;
    logic [31:0] PC;

    fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .PCSrc        (PCSrc),
        .BranchTarget (BranchTarget),
        .Jump         (Jump),
        .JumpTarget   (JumpTarget),
        .Stall        (Stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .Instr        (Instr),
        .InstrPC      (InstrPC),
        .InstrValid   (InstrValid),
        .PC           (PC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus and the state expected right after the following edge.
    typedef struct {
        logic        stall;
        logic        pcsrc;
        logic [31:0] btgt;
        logic        jump;
        logic [31:0] jtgt;
        logic        ack;
        logic        keep;   // ack whose data must reach decode
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_ipc;
    } vec_t;

    vec_t        tbl[$];
    logic [63:0] sb[$];   // {instr, instr_pc} expected at decode
    int          n_total = 0;
    int          n_pass  = 0;
    logic        prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic st, input logic ps, input logic [31:0] bt,
                                input logic jp, input logic [31:0] jt, input logic ak,
                                input logic kp, input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ei);
        vec_t v;
        v.stall = st; v.pcsrc = ps; v.btgt = bt; v.jump = jp; v.jtgt = jt;
        v.ack = ak; v.keep = kp; v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_ipc = ei;
        return v;
    endfunction

    task automatic apply(input vec_t v, input int idx);
        Stall        = v.stall;
        PCSrc        = v.pcsrc;
        BranchTarget = v.btgt;
        Jump         = v.jump;
        JumpTarget   = v.jtgt;
        imem_ack     = v.ack;
        imem_rdata   = 32'hA500_0000 | 32'(idx);
        if (v.keep) sb.push_back({imem_rdata, v.e_ipc});
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_req", idx),   32'(imem_req),   32'(v.e_req));
        chk($sformatf("v%0d_addr", idx),  imem_addr,       v.e_addr);
        chk($sformatf("v%0d_pc", idx),    PC,              v.e_addr);
        chk($sformatf("v%0d_valid", idx), 32'(InstrValid), 32'(v.e_valid));
        chk($sformatf("v%0d_ipc", idx),   InstrPC,         v.e_ipc);
        Stall = 1'b0; PCSrc = 1'b0; Jump = 1'b0; imem_ack = 1'b0;
    endtask

    // Each new instruction shows up as a rising InstrValid (consumption always leaves a gap).
    always @(negedge clk) begin
        if (rst_n) begin
            if (InstrValid && !prev_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_valid", 32'(InstrValid), 32'd0);
                end else begin
                    logic [63:0] e;
                    e = sb.pop_front();
                    chk("sb_instr", Instr, e[63:32]);
                    chk("sb_instr_pc", InstrPC, e[31:0]);
                end
            end
        end
        prev_valid = InstrValid;
    end

    initial begin
        rst_n = 1'b0; PCSrc = 1'b0; BranchTarget = '0; Jump = 1'b0; JumpTarget = '0;
        Stall = 1'b0; imem_ack = 1'b0; imem_rdata = '0;

        //        st ps  btgt          jp jtgt          ak kp req addr          vld ipc
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_0000, 0, 32'h0));           // 0 IDLE->FETCH
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 32'h0000_0004, 1, 32'h0));           // 1 zero-wait ack
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_0004, 0, 32'h0));           // 2 consumed
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 32'h0000_0008, 1, 32'h4));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_0008, 0, 32'h4));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 32'h0000_000C, 1, 32'h8));           // 5
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_000C, 0, 32'h8));           // 6 request 0xC
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_000C, 0, 32'h8));           // 7 wait
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_000C, 0, 32'h8));           // 8 wait
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_000C, 0, 32'h8));           // 9 wait
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 32'h0000_0010, 1, 32'hC));           // 10 late ack
        tbl.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_0010, 1, 32'hC));           // 11-14 stall
        tbl.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_0010, 1, 32'hC));
        tbl.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_0010, 1, 32'hC));
        tbl.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_0010, 1, 32'hC));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_0010, 0, 32'hC));           // 15 release
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 32'h0000_0014, 1, 32'h10));          // 16
        tbl.push_back(mk(1, 1, 32'h103,      0, 32'h0,        0, 0, 1, 32'h0000_0100, 0, 32'h10));          // 17 branch in HOLD
        tbl.push_back(mk(0, 1, 32'h200,      0, 32'h0,        0, 0, 1, 32'h0000_0100, 0, 32'h10));          // 18 branch mid-wait
        tbl.push_back(mk(0, 0, 32'h0,        1, 32'h300,      0, 0, 1, 32'h0000_0100, 0, 32'h10));          // 19 jump overwrites
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_0100, 0, 32'h10));          // 20
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 1, 32'h0000_0300, 0, 32'h10));          // 21 stale ack dropped
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 32'h0000_0304, 1, 32'h300));         // 22
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_0304, 0, 32'h300));         // 23
        tbl.push_back(mk(0, 1, 32'h40,       1, 32'h80,       1, 0, 1, 32'h0000_0080, 0, 32'h300));         // 24 redirect with ack
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 32'h0000_0084, 1, 32'h80));          // 25
        tbl.push_back(mk(1, 0, 32'h0,        1, 32'hFFFF_FFFE, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h80));         // 26 align
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 32'h0000_0000, 1, 32'hFFFF_FFFC));   // 27 wrap
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_0000, 0, 32'hFFFF_FFFC));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 32'h0000_0004, 1, 32'h0));           // 29
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_0004, 0, 32'h0));           // 30 request 0x4

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",   32'(imem_req),   32'd0);
        chk("rst_addr",  imem_addr,       32'h0);
        chk("rst_pc",    PC,              32'h0);
        chk("rst_instr", Instr,           32'h0);
        chk("rst_ipc",   InstrPC,         32'h0);
        chk("rst_valid", 32'(InstrValid), 32'd0);
        #3 rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Reset in the middle of an outstanding request takes effect without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req",   32'(imem_req),   32'd0);
        chk("midrst_pc",    PC,              32'h0);
        chk("midrst_ipc",   InstrPC,         32'h0);
        chk("midrst_instr", Instr,           32'h0);
        #4 rst_n = 1'b1;
        apply(mk(0, 0, 32'h0, 0, 32'h0, 0, 0, 1, 32'h0, 0, 32'h0), 100);
        apply(mk(0, 0, 32'h0, 0, 32'h0, 1, 1, 0, 32'h4, 1, 32'h0), 101);
        @(posedge clk);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
